// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared definitions for the CNN datapath blocks: output-mode
//                encodings, floating-point adder latency and a ceil(log2)
//                helper used for sizing pointers and counters.
//  Revision    : 1.0  initial release
// ============================================================================
package cnn_pkg;

  // Output selection for residual_align_add.
  typedef enum logic [1:0] {
    MODE_ADD      = 2'd0,   // main + shortcut
    MODE_ADD_RELU = 2'd1,   // main + shortcut, negatives forced to +0
    MODE_MAIN     = 2'd2,   // main operand passed through
    MODE_SC       = 2'd3    // shortcut operand passed through
  } mode_e;

  // Register stages inside fp_add_sub; the bypass delay line matches this.
  localparam int L_ADD = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_sub
//  Description : Pipelined IEEE-754 single-precision adder/subtractor,
//                round-to-nearest-even. Subnormal inputs and results are
//                flushed to zero. Three register stages (align, add,
//                normalise/round); result follows inputs by 3 clocks.
//  Ports       : clk    - rising-edge clock
//                a, b   - operands
//                sub    - 1: a - b, 0: a + b
//                result - a +/- b, three cycles after a/b/sub
//  Revision    : 1.0  initial release
// ============================================================================
module fp_add_sub (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result
);

  // ---------------- stage 1: unpack, order by magnitude, align -------------
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        a_big;
  logic        big_s;
  logic [7:0]  big_e, sml_e, diff;
  logic [23:0] big_m, sml_m;
  logic [4:0]  shamt;
  logic [50:0] wide;
  logic [26:0] sml_al;
  logic        spec;
  logic [31:0] spec_val;

  always_comb begin
    sa    = a[31];
    sb    = b[31] ^ sub;
    ea    = a[30:23];
    eb    = b[30:23];
    ma    = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb    = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    nan_a = (ea == 8'hFF) && (a[22:0] != 23'd0);
    nan_b = (eb == 8'hFF) && (b[22:0] != 23'd0);
    inf_a = (ea == 8'hFF) && (a[22:0] == 23'd0);
    inf_b = (eb == 8'hFF) && (b[22:0] == 23'd0);
    // Subnormals compare as zero so they never become the larger operand.
    a_big = ((ea == 8'd0) ? 31'd0 : a[30:0]) >= ((eb == 8'd0) ? 31'd0 : b[30:0]);
    big_s = a_big ? sa : sb;
    big_e = a_big ? ea : eb;
    big_m = a_big ? ma : mb;
    sml_e = a_big ? eb : ea;
    sml_m = a_big ? mb : ma;
    diff  = big_e - sml_e;
    // Anything shifted past 27 places lands entirely in the sticky bit.
    shamt = (diff > 8'd27) ? 5'd27 : diff[4:0];
    wide  = {sml_m, 27'd0} >> shamt;
    // Layout: {mantissa[23:0], guard, round, sticky}
    sml_al = {wide[50:25], wide[24] | (|wide[23:0])};
    spec   = nan_a | nan_b | inf_a | inf_b;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      spec_val = 32'h7FC0_0000;
    end else if (inf_a) begin
      spec_val = {sa, 8'hFF, 23'd0};
    end else begin
      spec_val = {sb, 8'hFF, 23'd0};
    end
  end

  logic        r1_sign, r1_sub, r1_spec;
  logic [7:0]  r1_exp;
  logic [26:0] r1_big, r1_sml;
  logic [31:0] r1_spec_val;

  always_ff @(posedge clk) begin
    r1_sign     <= big_s;
    r1_sub      <= sa ^ sb;
    r1_spec     <= spec;
    r1_spec_val <= spec_val;
    r1_exp      <= big_e;
    r1_big      <= {big_m, 3'b000};
    r1_sml      <= sml_al;
  end

  // ---------------- stage 2: magnitude add / subtract ----------------------
  logic        r2_sign, r2_sub, r2_spec;
  logic [7:0]  r2_exp;
  logic [27:0] r2_sum;
  logic [31:0] r2_spec_val;

  always_ff @(posedge clk) begin
    r2_sign     <= r1_sign;
    r2_sub      <= r1_sub;
    r2_spec     <= r1_spec;
    r2_spec_val <= r1_spec_val;
    r2_exp      <= r1_exp;
    r2_sum      <= r1_sub ? ({1'b0, r1_big} - {1'b0, r1_sml})
                          : ({1'b0, r1_big} + {1'b0, r1_sml});
  end

  // ---------------- stage 3: normalise, round, pack ------------------------
  logic [4:0]  lz;
  logic [26:0] norm;
  logic [9:0]  exp_n, exp_r;   // two's complement, range -27..257
  logic        round_up;
  logic [24:0] mant_r;
  logic [22:0] frac;
  logic [31:0] packed_res;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (r2_sum[i]) lz = 5'(26 - i);
    end
    if (r2_sum[27]) begin
      norm  = {r2_sum[27:2], r2_sum[1] | r2_sum[0]};
      exp_n = {2'b00, r2_exp} + 10'd1;
    end else begin
      norm  = r2_sum[26:0] << lz;
      exp_n = {2'b00, r2_exp} - {5'd0, lz};
    end
    round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    exp_r    = mant_r[24] ? (exp_n + 10'd1) : exp_n;
    frac     = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (r2_spec) begin
      packed_res = r2_spec_val;
    end else if (r2_sum == 28'd0) begin
      // Exact cancellation gives +0; like-signed zeros keep their sign.
      packed_res = {r2_sub ? 1'b0 : r2_sign, 31'd0};
    end else if (exp_r[9] || (exp_r == 10'd0)) begin
      packed_res = {r2_sign, 31'd0};
    end else if (exp_r >= 10'd255) begin
      packed_res = {r2_sign, 8'hFF, 23'd0};
    end else begin
      packed_res = {r2_sign, exp_r[7:0], frac};
    end
  end

  always_ff @(posedge clk) begin
    result <= packed_res;
  end

endmodule
`default_nettype wire

// File: rtl/residual_align_add.sv
`default_nettype none
// ============================================================================
//  Module      : residual_align_add
//  Description : Aligns a shortcut stream with a main stream through a
//                shortcut FIFO and combines each pair (add, add+ReLU, or pass
//                one operand). Fixed latency valid_main_in -> valid_out of
//                2 + L_ADD cycles for every mode.
//  Ports       : clk            - rising-edge clock
//                reset          - asynchronous active-low reset
//                valid_sc_in,
//                sc_in          - shortcut sample, queued in the FIFO
//                valid_main_in,
//                main_in        - main sample, consumes one shortcut entry
//                mode           - 0 add, 1 add+ReLU, 2 main pass, 3 sc pass
//                flag_clr       - synchronous clear of overflow/underflow
//                pxl_out,
//                valid_out      - result stream (pxl_out holds when idle)
//                frame_done     - pulse with the last output of a frame
//                sc_count       - FIFO occupancy
//                overflow,
//                underflow      - sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
module residual_align_add
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64,
  parameter int CHANNEL_NUM  = 1024,
  parameter int SC_DEPTH     = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_sc_in,
  input  logic [DATA_WIDTH-1:0]     sc_in,
  input  logic                      valid_main_in,
  input  logic [DATA_WIDTH-1:0]     main_in,
  input  logic [1:0]                mode,
  input  logic                      flag_clr,
  output logic [DATA_WIDTH-1:0]     pxl_out,
  output logic                      valid_out,
  output logic                      frame_done,
  output logic [clog2(SC_DEPTH):0]  sc_count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int ADDR_W    = clog2(SC_DEPTH);
  localparam int CNT_SC_W  = ADDR_W + 1;
  localparam int FRAME_LEN = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM;
  localparam int OUT_W     = clog2(FRAME_LEN + 1);
  localparam int LAST      = L_ADD - 1;

  // ---------------- shortcut FIFO ------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_mem [SC_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full;
  logic                  pop, push, bypass, pair_valid;
  logic                  ovf_set, unf_set;
  logic [DATA_WIDTH-1:0] pair_sc;

  always_comb begin
    fifo_empty = (sc_count == '0);
    fifo_full  = (sc_count == CNT_SC_W'(SC_DEPTH));
    pop        = valid_main_in && !fifo_empty;
    // Empty FIFO with a shortcut arriving alongside main: pair them directly.
    bypass     = valid_main_in && fifo_empty && valid_sc_in;
    push       = valid_sc_in && !bypass && (!fifo_full || pop);
    ovf_set    = valid_sc_in && fifo_full && !pop;
    unf_set    = valid_main_in && fifo_empty && !valid_sc_in;
    pair_valid = pop || bypass;
    // When full with a same-cycle pop, wr_ptr == rd_ptr: the read sees the
    // old entry because the write lands at the clock edge.
    pair_sc    = bypass ? sc_in : fifo_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sc_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sc_count  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   sc_count <= sc_count + CNT_SC_W'(1);
        2'b01:   sc_count <= sc_count - CNT_SC_W'(1);
        default: sc_count <= sc_count;
      endcase
      // A set event in the same cycle as flag_clr wins.
      if (ovf_set)       overflow  <= 1'b1;
      else if (flag_clr) overflow  <= 1'b0;
      if (unf_set)       underflow <= 1'b1;
      else if (flag_clr) underflow <= 1'b0;
    end
  end

  // ---------------- stage P: pair register ---------------------------------
  logic                  p_valid;
  mode_e                 p_mode;
  logic [DATA_WIDTH-1:0] p_main, p_sc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) p_valid <= 1'b0;
    else        p_valid <= pair_valid;
  end

  always_ff @(posedge clk) begin
    if (pair_valid) begin
      p_mode <= mode_e'(mode);
      p_main <= main_in;
      p_sc   <= pair_sc;
    end
  end

  // ---------------- adder and matched bypass delay line --------------------
  logic [31:0] add_res;

  fp_add_sub u_fp_add_sub (
    .clk    (clk),
    .a      (p_main),
    .b      (p_sc),
    .sub    (1'b0),
    .result (add_res)
  );

  logic                  dl_valid [L_ADD];
  mode_e                 dl_mode  [L_ADD];
  logic [DATA_WIDTH-1:0] dl_data  [L_ADD];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < L_ADD; i++) dl_valid[i] <= 1'b0;
    end else begin
      dl_valid[0] <= p_valid;
      for (int i = 1; i < L_ADD; i++) dl_valid[i] <= dl_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_mode[0] <= p_mode;
    dl_data[0] <= (p_mode == MODE_MAIN) ? p_main : p_sc;
    for (int i = 1; i < L_ADD; i++) begin
      dl_mode[i] <= dl_mode[i-1];
      dl_data[i] <= dl_data[i-1];
    end
  end

  // ---------------- stage O: select, ReLU, frame counter -------------------
  logic [DATA_WIDTH-1:0] out_sel;
  logic [OUT_W-1:0]      out_cnt;

  always_comb begin
    if (dl_mode[LAST] == MODE_ADD || dl_mode[LAST] == MODE_ADD_RELU) begin
      out_sel = add_res;
    end else begin
      out_sel = dl_data[LAST];
    end
    if (dl_mode[LAST] == MODE_ADD_RELU && out_sel[DATA_WIDTH-1]) begin
      out_sel = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      out_cnt    <= '0;
    end else begin
      valid_out  <= dl_valid[LAST];
      frame_done <= 1'b0;
      if (dl_valid[LAST]) begin
        pxl_out <= out_sel;
        if (out_cnt == OUT_W'(FRAME_LEN - 1)) begin
          out_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          out_cnt <= out_cnt + OUT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_residual_align_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_residual_align_add
//  Description : Self-checking bench for residual_align_add with a 4-entry
//                shortcut FIFO and a 2x2x2 frame. A behavioural model (queue
//                FIFO, real-valued arithmetic, fixed-latency expectation
//                queue) predicts every cycle's outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_residual_align_add;

  localparam int DEPTH = 4;
  localparam int FRAME = 8;     // 2 x 2 x 2
  localparam int LAT   = 5;     // 2 + three adder stages

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_sc_in, valid_main_in, flag_clr;
  logic [31:0] sc_in, main_in, pxl_out;
  logic [1:0]  mode;
  logic        valid_out, frame_done, overflow, underflow;
  logic [2:0]  sc_count;

  always #5 clk = ~clk;

  residual_align_add #(
    .DATA_WIDTH   (32),
    .IMAGE_WIDTH  (2),
    .IMAGE_HEIGHT (2),
    .CHANNEL_NUM  (2),
    .SC_DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_sc_in   (valid_sc_in),
    .sc_in         (sc_in),
    .valid_main_in (valid_main_in),
    .main_in       (main_in),
    .mode          (mode),
    .flag_clr      (flag_clr),
    .pxl_out       (pxl_out),
    .valid_out     (valid_out),
    .frame_done    (frame_done),
    .sc_count      (sc_count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sc_q [$];
  bit          pv   [$];
  logic [31:0] pd   [$];
  bit          m_ovf, m_unf;
  int          m_cnt, n_out, fd_at;
  logic [31:0] last_pxl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'd0) return 0.0;
    b = {f[31], 11'(32'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // Only used on values exactly representable in single precision.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int          e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Small dyadic values so every sum is exact in single precision.
  function automatic logic [31:0] rnd_val();
    int m;
    int k;
    m = int'($urandom_range(8190, 0)) - 4095;
    k = int'($urandom_range(8, 0));
    return r2f(real'(m) / real'(1 << k));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit vsc, input logic [31:0] sc, input bit vm,
                       input logic [31:0] mn, input logic [1:0] md, input bit clr);
    bit          ov_set, un_set, sc_used, pair, ev, fd;
    logic [31:0] op, res, ed;
    real         s;
    valid_sc_in   = vsc;
    sc_in         = sc;
    valid_main_in = vm;
    main_in       = mn;
    mode          = md;
    flag_clr      = clr;
    ov_set = 0; un_set = 0; sc_used = 0; pair = 0; op = 0; res = 0; ed = 0;
    if (vm) begin
      if (sc_q.size() > 0) begin
        op = sc_q.pop_front();
        pair = 1;
      end else if (vsc) begin
        op = sc;
        sc_used = 1;
        pair = 1;
      end else begin
        un_set = 1;
      end
    end
    if (vsc && !sc_used) begin
      if (sc_q.size() < DEPTH) sc_q.push_back(sc);
      else ov_set = 1;
    end
    if (pair) begin
      s = f2r(mn) + f2r(op);
      case (md)
        2'd0:    res = r2f(s);
        2'd1:    res = (s < 0.0) ? 32'd0 : r2f(s);
        2'd2:    res = mn;
        default: res = op;
      endcase
    end
    m_ovf = ov_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = un_set ? 1'b1 : (clr ? 1'b0 : m_unf);
    pv.push_back(pair);
    pd.push_back(res);
    tick();
    valid_sc_in   = 0;
    valid_main_in = 0;
    flag_clr      = 0;
    chk("sc_count", 32'(sc_count), 32'(sc_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    ev = 0;
    if (pv.size() == LAT) begin
      ev = pv.pop_front();
      ed = pd.pop_front();
    end
    chk("valid_out", 32'(valid_out), 32'(ev));
    fd = 0;
    if (ev) begin
      fd = (m_cnt == FRAME - 1);
      m_cnt = fd ? 0 : m_cnt + 1;
      last_pxl = ed;
      n_out++;
      if (fd) fd_at = n_out;
    end
    chk("pxl_out", pxl_out, last_pxl);
    chk("frame_done", 32'(frame_done), 32'(fd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'd0, 0, 32'd0, 2'd0, 0);
  endtask

  // Asynchronous reset: outputs must clear before any further clock edge.
  task automatic do_reset();
    reset         = 0;
    valid_sc_in   = 0;
    valid_main_in = 0;
    flag_clr      = 0;
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_sc_count", 32'(sc_count), 32'd0);
    chk("rst_pxl_out", pxl_out, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    sc_q.delete();
    pv.delete();
    pd.delete();
    m_ovf = 0; m_unf = 0; m_cnt = 0; n_out = 0; fd_at = 0;
    last_pxl = 32'd0;
    tick();
    tick();
    reset = 1;
  endtask

  initial begin
    reset = 1; valid_sc_in = 0; valid_main_in = 0; flag_clr = 0;
    sc_in = 0; main_in = 0; mode = 0;
    #3;
    do_reset();

    // 1.0 on shortcut, 2.0 on main five cycles later, add
    cycle(1, 32'h3F80_0000, 0, 32'd0, 2'd0, 0);
    idle(4);
    cycle(0, 32'd0, 1, 32'h4000_0000, 2'd0, 0);
    idle(LAT);
    chk("add_1_plus_2", pxl_out, 32'h4040_0000);

    // -3.0 + 1.0: plain add, ReLU, main pass, shortcut pass
    cycle(1, 32'hC040_0000, 0, 32'd0, 2'd0, 0);
    cycle(0, 32'd0, 1, 32'h3F80_0000, 2'd0, 0);
    idle(LAT);
    chk("add_neg", pxl_out, 32'hC000_0000);
    cycle(1, 32'hC040_0000, 0, 32'd0, 2'd0, 0);
    cycle(0, 32'd0, 1, 32'h3F80_0000, 2'd1, 0);
    idle(LAT);
    chk("relu_neg", pxl_out, 32'h0000_0000);
    cycle(1, 32'hC040_0000, 0, 32'd0, 2'd0, 0);
    cycle(0, 32'd0, 1, 32'h3F80_0000, 2'd2, 0);
    idle(LAT);
    chk("main_pass", pxl_out, 32'h3F80_0000);
    cycle(1, 32'hC040_0000, 0, 32'd0, 2'd0, 0);
    cycle(0, 32'd0, 1, 32'h3F80_0000, 2'd3, 0);
    idle(LAT);
    chk("sc_pass", pxl_out, 32'hC040_0000);

    // Five pushes into a 4-deep FIFO, then clear and drain
    for (int i = 1; i <= 5; i++) cycle(1, r2f(real'(i)), 0, 32'd0, 2'd0, 0);
    chk("ovf_count", 32'(sc_count), 32'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    cycle(0, 32'd0, 0, 32'd0, 2'd0, 1);
    chk("ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) cycle(0, 32'd0, 1, 32'd0, 2'd3, 0);
    idle(LAT);
    chk("drain_last", pxl_out, 32'h4080_0000);

    // Underflow, then same-cycle shortcut forwarding
    cycle(0, 32'd0, 1, 32'h3F80_0000, 2'd0, 0);
    chk("unf_set", 32'(underflow), 32'd1);
    idle(LAT);
    cycle(0, 32'd0, 0, 32'd0, 2'd0, 1);
    cycle(1, 32'h3F80_0000, 1, 32'h3F80_0000, 2'd0, 0);
    chk("bypass_count", 32'(sc_count), 32'd0);
    idle(LAT);
    chk("bypass_sum", pxl_out, 32'h4000_0000);

    // Frame boundary: continuous pairs, pulse on 8th and 16th outputs
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, rnd_val(), 1, rnd_val(), 2'd0, 0);
    idle(LAT);
    chk("frame_done_at_8", 32'(fd_at), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1, rnd_val(), 1, rnd_val(), 2'(i % 4), 0);
    idle(LAT);
    chk("frame_done_at_16", 32'(fd_at), 32'd16);

    // Reset with three entries queued and two pairs in flight
    for (int i = 0; i < 3; i++) cycle(1, rnd_val(), 0, 32'd0, 2'd0, 0);
    for (int i = 0; i < 2; i++) cycle(1, rnd_val(), 1, rnd_val(), 2'd0, 0);
    chk("pre_reset_count", 32'(sc_count), 32'd3);
    do_reset();
    idle(LAT + 3);
    cycle(0, 32'd0, 1, rnd_val(), 2'd0, 0);
    chk("post_reset_unf", 32'(underflow), 32'd1);
    idle(LAT);

    // Randomised traffic with mode changes mid-pipe
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(99, 0) < 60, rnd_val(),
            $urandom_range(99, 0) < 50, rnd_val(),
            2'($urandom_range(3, 0)),
            $urandom_range(99, 0) < 5);
    end
    idle(LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
